bcd_add_sequencer: RTL
======================

BCD_ADD_SEQUENCER -- requirements
Module: bcd_add_sequencer

Interface
REQ-001 SHALL have parameter DIGITS, default 4, number of BCD digits per operand (legal 1..8).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request to begin one addition; sampled only in IDLE.
REQ-005 SHALL have port cin  input  1  decimal carry-in for the operation.
REQ-006 SHALL have port a  input  4*DIGITS  BCD operand A, digit 0 in bits [3:0].
REQ-007 SHALL have port b  input  4*DIGITS  BCD operand B, same packing as a.
REQ-008 SHALL have port busy  output  1  high while an operation is in progress (CALC state).
REQ-009 SHALL have port done  output  1  one-cycle pulse marking s/err valid.
REQ-010 SHALL have port s  output  4*DIGITS+1  BCD result; MSB is the final decimal carry.
REQ-011 SHALL have port err  output  1  high if any operand digit of the last operation was >9.

Function
REQ-012 SHALL contain exactly one shared single-digit BCD add stage, time-multiplexed across digits, one digit per clock.
REQ-013 SHALL implement FSM states IDLE, CALC, DONE.
REQ-014 IDLE: start=1 -> latch a, b, cin into internal registers, clear working sum and err accumulator, digit index=0, go CALC; start=0 -> stay IDLE.
REQ-015 CALC: each cycle add latched digit[idx] of A and B plus carry register; write result digit idx of working sum; update carry; idx+1.
REQ-016 CALC with idx=DIGITS-1 -> after that digit, go DONE; otherwise stay CALC.
REQ-017 DONE: lasts exactly one cycle, then IDLE unconditionally; start during DONE is ignored.
REQ-018 Digit rule: t = da + db + c (5-bit); if t>9 then digit=(t+6) mod 16, carry=1; else digit=t, carry=0.
REQ-019 Digits >9 SHALL NOT be rejected; they are processed by REQ-018 and set the err accumulator.
REQ-020 Latency: start high in IDLE at cycle n -> CALC cycles n+1..n+DIGITS -> done=1 in cycle n+DIGITS+1 only.
REQ-021 s and err SHALL be registered outputs, loaded on the CALC->DONE transition, held stable until the next CALC->DONE transition.
REQ-022 s[4*DIGITS] SHALL equal the carry out of the most significant digit.
REQ-023 busy=1 exactly in CALC cycles; done=1 exactly in DONE cycle; never both.
REQ-024 start held continuously high SHALL yield one operation every DIGITS+2 cycles.
REQ-025 Operand inputs changing after start acceptance SHALL NOT affect the running operation.

Reset
REQ-026 reset=1 at a rising edge SHALL force IDLE, busy=0, done=0, s=0, err=0, idx=0, carry=0.
REQ-027 reset SHALL take priority over start and over any in-progress operation; an aborted operation SHALL produce no done pulse and no s update.
REQ-028 After reset deasserts, a start in the first cycle SHALL be accepted normally.

Verification (DIGITS=4)
REQ-029 a=0x1234, b=0x5678, cin=0, start at cycle n -> busy n+1..n+4, done at n+5, s=0x06912, err=0.
REQ-030 a=0x9999, b=0x0001, cin=0 -> s=0x10000; a=0x9999, b=0x9999, cin=1 -> s=0x19999; err=0 both.
REQ-031 a=0x000A, b=0x0000, cin=0 -> s=0x00010, err=1; next op a=0x0001, b=0x0001 -> s=0x00002, err=0.
REQ-032 start pulsed at n, again at n+2 and n+5 with different operands -> both ignored; single done at n+5 with first operands' result; start at n+6 accepted.
REQ-033 start at n, reset at n+2 -> busy=0 from n+3, no done through n+8, s=0, err=0.
REQ-034 start held high 12 cycles from n with a=0x0005, b=0x0005 -> done at n+5 and n+11, s=0x00010 each.

Source files
------------

// File: rtl/bcd_add_sequencer.sv
// rtl/bcd_add_sequencer.sv - multi-digit BCD adder using one shared digit stage, one digit per clock
module bcd_add_sequencer #(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                cin,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS:0]   s,
  output logic                err
);

  localparam int W = 4 * DIGITS;
  localparam logic [3:0] LAST = 4'(DIGITS - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t       state;
  logic [W-1:0] a_r;
  logic [W-1:0] b_r;
  logic [W-1:0] work;
  logic [W-1:0] work_next;
  logic [3:0]   idx;
  logic         carry;
  logic         err_acc;

  logic [3:0] da;
  logic [3:0] db;
  logic [4:0] t;
  logic [3:0] dig;
  logic       cout;
  logic       digit_bad;

  // The single shared digit stage: select digit idx, add, decimal-correct
  always_comb begin
    da        = 4'd0;
    db        = 4'd0;
    work_next = work;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == 4'(i)) begin
        da = a_r[4*i +: 4];
        db = b_r[4*i +: 4];
      end
    end
    t = {1'b0, da} + {1'b0, db} + {4'd0, carry};
    if (t > 5'd9) begin
      dig  = t[3:0] + 4'd6;
      cout = 1'b1;
    end else begin
      dig  = t[3:0];
      cout = 1'b0;
    end
    digit_bad = (da > 4'd9) || (db > 4'd9);
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == 4'(i)) begin
        work_next[4*i +: 4] = dig;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      s       <= '0;
      err     <= 1'b0;
      idx     <= 4'd0;
      carry   <= 1'b0;
      a_r     <= '0;
      b_r     <= '0;
      work    <= '0;
      err_acc <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_r     <= a;
            b_r     <= b;
            carry   <= cin;
            work    <= '0;
            err_acc <= 1'b0;
            idx     <= 4'd0;
            busy    <= 1'b1;
            state   <= CALC;
          end
        end
        CALC: begin
          work    <= work_next;
          carry   <= cout;
          err_acc <= err_acc | digit_bad;
          if (idx == LAST) begin
            // Results publish only here, so an aborted run never touches s/err
            s     <= {cout, work_next};
            err   <= err_acc | digit_bad;
            busy  <= 1'b0;
            done  <= 1'b1;
            idx   <= 4'd0;
            state <= DONE;
          end else begin
            idx <= idx + 4'd1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
